// File: rtl/rr_decode_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter_pkg : shared constants and grant decode for the arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rr_decode_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int HOLD_W  = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // 2-to-4 enable decode that turns the owner index into the one-hot grant
  function automatic logic [NUM_REQ-1:0] decode_en(input logic [ID_W-1:0] id,
                                                   input logic            en);
    decode_en = en ? (NUM_REQ'(1) << id) : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_decode_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : rotated priority search starting just after the last winner
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import rr_decode_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    win_id,
  output logic               win_vld
);

  // Walk from lowest to highest priority so the last hit is the winner;
  // offset NUM_REQ wraps to last itself, which therefore ranks lowest.
  always_comb begin
    win_id  = last;
    win_vld = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[last + ID_W'(i)]) begin
        win_id  = last + ID_W'(i);
        win_vld = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decode_arbiter : 4-way round-robin arbiter with hold timer, one-hot grant
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_decode_arbiter
  import rr_decode_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [0:0]        state;
  logic [ID_W-1:0]   last;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ID_W-1:0]   win_id;
  logic              win_vld;

  rr_pick u_pick (
    .req     (req),
    .last    (last),
    .win_id  (win_id),
    .win_vld (win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last     <= ID_W'(NUM_REQ - 1);
      hold_cnt <= '0;
      gnt_id   <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            gnt_id   <= win_id;
            gnt_vld  <= 1'b1;
            last     <= win_id;
            hold_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          hold_cnt <= hold_cnt + 1'b1;
          // A release wins over the timer, so timeout only fires for a live owner
          if (!req[gnt_id]) begin
            gnt_vld <= 1'b0;
            state   <= ST_IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            gnt_vld <= 1'b0;
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign gnt = decode_en(gnt_id, gnt_vld);

endmodule

`default_nettype wire

// File: tb/tb_rr_decode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_decode_arbiter : directed self-checking bench, HOLD_MAX = 4
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rr_decode_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       timeout;

  int n_cmp;
  int n_err;

  rr_decode_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: gnt=%b id=%0d vld=%b to=%b required 0000/0/0/0", gnt, gnt_id, gnt_vld, timeout);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: gnt=%b vld=%b to=%b required 0000/0/0", gnt, gnt_vld, timeout);
    end
  endtask

  task automatic test_basic();
    req = 4'b0001;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || gnt_vld !== 1'b1) begin
      n_err++;
      $display("FAIL basic_grant: gnt=%b id=%0d vld=%b required 0001/0/1", gnt, gnt_id, gnt_vld);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL basic_hold: gnt=%b required 0001", gnt);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL basic_release: gnt=%b vld=%b to=%b required 0000/0/0", gnt, gnt_vld, timeout);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [3:0] drop;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      step();
      n_cmp++;
      if (gnt !== exp_gnt || gnt_id !== 2'(k % 4)) begin
        n_err++;
        $display("FAIL rr_order[%0d]: gnt=%b id=%0d required %b/%0d", k, gnt, gnt_id, exp_gnt, k % 4);
      end
      step();
      n_cmp++;
      if (gnt !== exp_gnt) begin
        n_err++;
        $display("FAIL rr_hold[%0d]: gnt=%b required %b", k, gnt, exp_gnt);
      end
      drop = 4'b1111 & ~exp_gnt;
      req  = drop;
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL rr_gap[%0d]: gnt=%b to=%b required 0000/0", k, gnt, timeout);
      end
      req = 4'b1111;
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0010 || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL to_hold[%0d]: gnt=%b to=%b required 0010/0", c, gnt, timeout);
      end
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0 || timeout !== 1'b1) begin
      n_err++;
      $display("FAIL to_revoke: gnt=%b vld=%b to=%b required 0000/0/1", gnt, gnt_vld, timeout);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL to_regrant: gnt=%b id=%0d to=%b required 0010/1/0", gnt, gnt_id, timeout);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_fairness();
    do_reset();
    req = 4'b0110;
    for (int c = 0; c < 4; c++) step();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_err++;
      $display("FAIL fair_first: gnt=%b required 0010", gnt);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_err++;
      $display("FAIL fair_to1: gnt=%b to=%b required 0000/1", gnt, timeout);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      n_err++;
      $display("FAIL fair_second: gnt=%b id=%0d required 0100/2", gnt, gnt_id);
    end
    for (int c = 0; c < 4; c++) step();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_err++;
      $display("FAIL fair_to2: gnt=%b to=%b required 0000/1", gnt, timeout);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
      n_err++;
      $display("FAIL fair_third: gnt=%b id=%0d required 0010/1", gnt, gnt_id);
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0001;
    step();
    for (int c = 0; c < 3; c++) step();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL sim_last_cycle: gnt=%b required 0001", gnt);
    end
    req = 4'b0000;
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL sim_release: gnt=%b to=%b required 0000/0", gnt, timeout);
    end
    step();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL sim_after: gnt=%b to=%b required 0000/0", gnt, timeout);
    end
  endtask

  task automatic test_reset_midgrant();
    do_reset();
    req = 4'b0100;
    step();
    n_cmp++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      n_err++;
      $display("FAIL mid_grant: gnt=%b id=%0d required 0100/2", gnt, gnt_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || gnt_id !== 2'd0 || gnt_vld !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async_clear: gnt=%b id=%0d vld=%b required 0000/0/0", gnt, gnt_id, gnt_vld);
    end
    req = 4'b0101;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reprio: gnt=%b id=%0d required 0001/0", gnt, gnt_id);
    end
    req = 4'b0000;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_fairness();
    test_simultaneous();
    test_reset_midgrant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
